// File: rtl/spm_pkg.sv
// spm_pkg: shared widths, state encoding and stream lag for the SPM product collector
package spm_pkg;
  localparam int PROD_W = 64;
  localparam int CNT_W = 7;
  localparam int CMP_LAG = 1;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPTURE = 2'd1,
    HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/spm_product_collector_flipflop.sv
// FlipFlop: single-bit D flop with synchronous active-low clear
module FlipFlop (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk)
    if (!rst) q <= 1'b0;
    else q <= d;
endmodule

// File: rtl/spm_product_collector.sv
// spm_product_collector: aligns raw/complemented serial product streams and assembles a parallel product
module spm_product_collector #(
  parameter int PROD_W = spm_pkg::PROD_W,
  parameter int CNT_W = spm_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              neg,
  input  logic              raw_bit,
  input  logic              cmp_bit,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);
  import spm_pkg::*;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PROD_W - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PROD_W-1:0] sreg_q, sreg_d, prod_q, prod_d;
  logic neg_q, neg_d, raw_d, sel_bit;
  // raw stream delayed by one cycle to line up with the complementor output
  FlipFlop u_dly (.clk(clk), .rst(rst), .d(raw_bit), .q(raw_d));
  assign sel_bit = neg_q ? cmp_bit : raw_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sreg_d = sreg_q;
    prod_d = prod_q;
    neg_d = neg_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CAPTURE;
        neg_d = neg;
        cnt_d = '0;
      end
      CAPTURE: begin
        sreg_d = {sel_bit, sreg_q[PROD_W-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          prod_d = sreg_d;
          state_d = HOLD;
        end
      end
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sreg_q <= '0;
      prod_q <= '0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sreg_q <= sreg_d;
      prod_q <= prod_d;
      neg_q <= neg_d;
    end
  assign busy = (state_q == CAPTURE) || (state_q == HOLD);
  assign out_valid = state_q == HOLD;
  assign product = prod_q;
endmodule

// File: tb/tb_spm_product_collector.sv
// tb_spm_product_collector: randomized self-checking bench against a serial-stream reference model
module tb_spm_product_collector;
  logic clk = 0, rst = 0, start = 0, neg = 0, raw_bit = 0, cmp_bit = 0, out_ready = 0;
  logic busy, out_valid;
  logic [63:0] product;
  int vectors = 0, miscompares = 0;

  spm_product_collector dut (
    .clk(clk), .rst(rst), .start(start), .neg(neg), .raw_bit(raw_bit), .cmp_bit(cmp_bit),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one product: raw on cycle T+j carries bit j, cmp lags by one cycle.
  task automatic drive_frame(input string name, input logic [63:0] raw, input logic [63:0] cmp,
                             input logic n, input logic [63:0] exp, input int restart_at);
    logic early;
    early = 0;
    start = 1;
    neg = n;
    raw_bit = raw[0];
    cmp_bit = 1'($urandom);
    for (int j = 1; j <= 64; j++) begin
      step();
      if (out_valid) early = 1;
      start = (j == restart_at);
      neg = 1'($urandom);
      raw_bit = (j < 64) ? raw[j] : 1'($urandom);
      cmp_bit = cmp[j-1];
    end
    step();
    start = 0;
    vectors++;
    if (early !== 1'b0) begin
      miscompares++;
      $display("FAIL %s early_valid: out_valid rose before 65 cycles", name);
    end
    vectors++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s latency: out_valid=%b busy=%b, required 1/1 at start+65", name, out_valid, busy);
    end
    vectors++;
    if (product !== exp) begin
      miscompares++;
      $display("FAIL %s product: got %h, required %h", name, product, exp);
    end
  endtask

  task automatic finish_hs(input string name);
    out_ready = 1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s handshake: out_valid=%b busy=%b, required 0/0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) step();
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || product !== 64'h0) begin
      miscompares++;
      $display("FAIL reset: busy=%b out_valid=%b product=%h, required 0/0/0", busy, out_valid, product);
    end
    rst = 1;
    step();
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b out_valid=%b, required 0/0", busy, out_valid);
    end
  endtask

  task automatic test_positive();
    out_ready = 0;
    drive_frame("positive", 64'h5, '1, 1'b0, 64'h5, -1);
    finish_hs("positive");
    out_ready = 0;
  endtask

  task automatic test_negative();
    logic [63:0] mag;
    mag = 64'd6;
    drive_frame("negative", mag, -mag, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, -1);
    finish_hs("negative");
    out_ready = 0;
    // raw garbage must not leak into a negative product
    drive_frame("negative_raw_ignored", {$urandom, $urandom}, -mag, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, -1);
    finish_hs("negative_raw_ignored");
    out_ready = 0;
  endtask

  task automatic test_backpressure();
    logic [63:0] mag;
    logic held;
    mag = {$urandom, $urandom};
    out_ready = 0;
    drive_frame("backpressure", mag, {$urandom, $urandom}, 1'b0, mag, -1);
    held = 1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      step();
      if (out_valid !== 1'b1 || product !== mag) held = 0;
    end
    start = 0;
    vectors++;
    if (held !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_hold: out_valid=%b product=%h, required 1/%h", out_valid, product, mag);
    end
    finish_hs("backpressure");
    out_ready = 0;
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_start_ignored: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] raw;
    raw = {$urandom, $urandom};
    start = 1;
    neg = 0;
    raw_bit = raw[0];
    for (int j = 1; j <= 20; j++) begin
      step();
      start = 0;
      raw_bit = raw[j];
      cmp_bit = 1'($urandom);
    end
    rst = 0;
    step();
    rst = 1;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || product !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b out_valid=%b product=%h, required 0/0/0", busy, out_valid, product);
    end
    drive_frame("after_reset", 64'h8000_0000_0000_0001, {$urandom, $urandom}, 1'b0,
                64'h8000_0000_0000_0001, -1);
    finish_hs("after_reset");
    out_ready = 0;
  endtask

  task automatic test_start_busy();
    logic [63:0] mag;
    int episodes;
    mag = {$urandom, $urandom};
    drive_frame("start_busy", mag, -mag, 1'b1, -mag, 10);
    finish_hs("start_busy");
    out_ready = 0;
    episodes = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (out_valid || busy) episodes++;
    end
    vectors++;
    if (episodes !== 0) begin
      miscompares++;
      $display("FAIL start_busy_extra: %0d busy cycles after handshake, required 0", episodes);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    drive_frame("b2b_first", 64'h1234_5678_9ABC_DEF0, {$urandom, $urandom}, 1'b0,
                64'h1234_5678_9ABC_DEF0, -1);
    finish_hs("b2b_first");
    drive_frame("b2b_second", 64'h1, {$urandom, $urandom}, 1'b0, 64'h1, -1);
    finish_hs("b2b_second");
    out_ready = 0;
  endtask

  task automatic test_random();
    logic [63:0] mag;
    logic n;
    for (int k = 0; k < 8; k++) begin
      mag = {$urandom, $urandom};
      n = 1'($urandom);
      drive_frame("random", mag, n ? -mag : {$urandom, $urandom}, n, n ? -mag : mag, -1);
      repeat ($urandom_range(0, 4)) step();
      finish_hs("random");
      out_ready = 0;
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
